// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding and latched SPI mode.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_XFER  = 2'd2,
        ST_TRAIL = 2'd3
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: pulses once every div+1 cycles while enabled,
// counter held at zero when disabled so every transfer starts phase-aligned.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!en || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/spi_master_param.sv
// Parameterized SPI master, all four cpol/cpha modes, per-transfer chip select.
// Optional LSB-first port is compiled in when SPI_LSB_FIRST_EN is defined.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CS_NUM = 4,
    parameter int DIV_W  = 8
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    output logic                                         busy,
    output logic                                         done,
    input  logic [DATA_W-1:0]                            din,
    output logic [DATA_W-1:0]                            dout,
    input  logic [((CS_NUM > 1) ? $clog2(CS_NUM) : 1)-1:0] cs_sel,
    input  logic                                         cpol,
    input  logic                                         cpha,
    input  logic [DIV_W-1:0]                             clk_div,
`ifdef SPI_LSB_FIRST_EN
    input  logic                                         lsb_first,
`endif
    output logic                                         sck,
    output logic                                         mosi,
    input  logic                                         miso,
    output logic [CS_NUM-1:0]                            cs_n
);

    localparam int              HC_W    = $clog2(2 * DATA_W);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(2 * DATA_W - 1);

    spi_state_e        state;
    spi_mode_t         mode_q;
    logic [DIV_W-1:0]  div_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [HC_W-1:0]   hcnt;
    logic [CS_NUM-1:0] cs_dec;
    logic              tick;
    logic              lsb_in;
    logic              lsb_q;
    logic              edge_now;
    logic              lead_edge;
    logic              samp;
    logic              shft;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lsb_q <= 1'b0;
        else if (state == ST_IDLE && start)
            lsb_q <= lsb_first;
    end
`else
    assign lsb_in = 1'b0;
    assign lsb_q  = 1'b0;
`endif

    spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != ST_IDLE),
        .div   (div_q),
        .tick  (tick)
    );

    // SCK edges fall on the LEAD->XFER boundary and every internal XFER
    // boundary: 2*DATA_W edges, even-numbered ones are leading.
    always_comb begin
        edge_now  = 1'b0;
        lead_edge = 1'b0;
        if (tick && state == ST_LEAD) begin
            edge_now  = 1'b1;
            lead_edge = 1'b1;
        end else if (tick && state == ST_XFER && hcnt != HC_LAST) begin
            edge_now  = 1'b1;
            lead_edge = hcnt[0];
        end
    end

    assign samp = edge_now && (lead_edge != mode_q.cpha);
    assign shft = edge_now && (lead_edge == mode_q.cpha);

    // Out-of-range selects decode to no active chip select.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < CS_NUM; i++)
            cs_dec[i] = (int'(cs_sel) != i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mode_q <= '0;
            div_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            hcnt   <= '0;
            cs_n   <= '1;
            sck    <= 1'b0;
            mosi   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dout   <= '0;
        end else begin
            done <= 1'b0;
            if (samp)
                rx_q <= lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
            if (shft) begin
                mosi <= lsb_q ? tx_q[0] : tx_q[DATA_W-1];
                tx_q <= lsb_q ? (tx_q >> 1) : (tx_q << 1);
            end
            if (edge_now)
                sck <= ~sck;

            case (state)
                ST_IDLE: begin
                    mosi <= 1'b0;
                    if (start) begin
                        state       <= ST_LEAD;
                        busy        <= 1'b1;
                        cs_n        <= cs_dec;
                        sck         <= cpol;
                        mode_q.cpol <= cpol;
                        mode_q.cpha <= cpha;
                        div_q       <= clk_div;
                        // cpha=0 needs the first bit on the wire before the first edge
                        if (!cpha) begin
                            mosi <= lsb_in ? din[0] : din[DATA_W-1];
                            tx_q <= lsb_in ? (din >> 1) : (din << 1);
                        end else begin
                            tx_q <= din;
                        end
                    end
                end
                ST_LEAD: begin
                    if (tick) begin
                        state <= ST_XFER;
                        hcnt  <= '0;
                    end
                end
                ST_XFER: begin
                    if (tick) begin
                        if (hcnt == HC_LAST)
                            state <= ST_TRAIL;
                        else
                            hcnt <= hcnt + 1'b1;
                    end
                end
                ST_TRAIL: begin
                    if (tick) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cs_n  <= '1;
                        dout  <= rx_q;
                        mosi  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: directed transfers push expected dout,
// a done-triggered monitor pops and compares; a per-mode slave model drives miso.
module tb_spi_master_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic [1:0]  cs_sel = '0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic [7:0]  clk_div = '0;
    logic        sck;
    logic        mosi;
    logic        miso;
    logic [3:0]  cs_n;
`ifdef SPI_LSB_FIRST_EN
    logic        lsb_first = 1'b0;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          n_done = 0;
    logic [31:0] sb[$];

    // slave model state
    logic        loop = 1'b0;
    logic        s_miso = 1'b0;
    logic [31:0] s_data = '0;
    logic [31:0] s_rx = '0;
    logic        s_act = 1'b0;
    logic        s_prev = 1'b0;
    logic        s_lead;
    logic        m_cpol = 1'b0;
    logic        m_cpha = 1'b0;
    int          s_idx = 0;

    assign miso = loop ? mosi : s_miso;

    always #5 clk = ~clk;

    spi_master_param #(.DATA_W(32), .CS_NUM(4), .DIV_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .din       (din),
        .dout      (dout),
        .cs_sel    (cs_sel),
        .cpol      (cpol),
        .cpha      (cpha),
        .clk_div   (clk_div),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .sck       (sck),
        .mosi      (mosi),
        .miso      (miso),
        .cs_n      (cs_n)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Mode-aware slave: cpha=0 presents bit on CS fall and shifts on trailing
    // edges; cpha=1 shifts on leading edges. Records mosi on its sample edges.
    always @(negedge clk) begin
        if (&cs_n) begin
            s_act  = 1'b0;
            s_miso = 1'b0;
        end else if (!s_act) begin
            s_act  = 1'b1;
            s_prev = sck;
            s_idx  = 31;
            if (!m_cpha) begin
                s_miso = s_data[31];
                s_idx  = 30;
            end
        end else if (sck != s_prev) begin
            s_prev = sck;
            s_lead = (sck != m_cpol);
            if (s_lead == m_cpha) begin
                if (s_idx >= 0) begin
                    s_miso = s_data[s_idx];
                    s_idx--;
                end
            end else begin
                s_rx = {s_rx[30:0], mosi};
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0)
                chk("done_with_empty_sb", 32'(sb.size()), 32'd1);
            else
                chk("dout", dout, sb.pop_front());
        end
    end

    // Called at a negedge with the DUT idle; returns at the first busy negedge.
    task automatic launch(input logic [31:0] d, input logic [1:0] sel, input logic pol,
                          input logic pha, input logic [7:0] div, input bit push,
                          input logic [31:0] exp);
        din = d; cs_sel = sel; cpol = pol; cpha = pha; clk_div = div;
        m_cpol = pol; m_cpha = pha;
        if (push) sb.push_back(exp);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input logic [3:0] exp_cs, output int width, output int cs_bad);
        width = 0;
        cs_bad = 0;
        while (busy && width < 20000) begin
            width++;
            if (cs_n != exp_cs) cs_bad++;
            @(negedge clk);
        end
    endtask

    initial begin
        int w, bad, snap;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 32'hF);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout", dout, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // mode 0, div 0, loopback
        loop = 1'b1;
        snap = n_done;
        launch(32'hA5C3_0F81, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, 32'hA5C3_0F81);
        chk("m0_first_mosi", 32'(mosi), 32'd1);
        wait_idle(4'b1110, w, bad);
        chk("m0_busy_width", 32'(w), 32'd66);
        chk("m0_cs_hold", 32'(bad), 32'd0);
        chk("m0_done_pulse", 32'(done), 32'd1);
        chk("m0_mosi_stream", s_rx, 32'hA5C3_0F81);
        @(negedge clk);
        chk("m0_done_low", 32'(done), 32'd0);
        chk("m0_idle_mosi", 32'(mosi), 32'd0);
        chk("m0_idle_sck", 32'(sck), 32'd0);
        repeat (3) @(negedge clk);
        chk("m0_done_count", 32'(n_done - snap), 32'd1);

        // all four modes, div 3, slave returns 0x12345678
        loop = 1'b0;
        s_data = 32'h1234_5678;
        for (int m = 0; m < 4; m++) begin
            launch(32'h3C96_F00D, 2'd0, m[1], m[0], 8'd3, 1'b1, 32'h1234_5678);
            chk("mode_lead_sck", 32'(sck), 32'(m[1]));
            wait_idle(4'b1110, w, bad);
            chk("mode_busy_width", 32'(w), 32'd264);
            chk("mode_cs_hold", 32'(bad), 32'd0);
            chk("mode_mosi_stream", s_rx, 32'h3C96_F00D);
            chk("mode_idle_sck", 32'(sck), 32'(m[1]));
            repeat (2) @(negedge clk);
        end

        // chip select 2
        loop = 1'b1;
        launch(32'h0BAD_F00D, 2'd2, 1'b0, 1'b0, 8'd0, 1'b1, 32'h0BAD_F00D);
        wait_idle(4'b1011, w, bad);
        chk("cs2_hold", 32'(bad), 32'd0);
        chk("cs2_after", 32'(cs_n), 32'hF);
        repeat (2) @(negedge clk);

        // chip select 3 with a start pulse during busy
        snap = n_done;
        launch(32'h0F0F_1234, 2'd3, 1'b0, 1'b0, 8'd0, 1'b1, 32'h0F0F_1234);
        repeat (10) @(negedge clk);
        din = 32'hFFFF_FFFF;
        cs_sel = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(4'b0111, w, bad);
        chk("cs3_hold", 32'(bad), 32'd0);
        repeat (6) @(negedge clk);
        chk("ignored_start_done", 32'(n_done - snap), 32'd1);
        chk("ignored_start_busy", 32'(busy), 32'd0);

        // reset in the middle of bit 10, mode 2
        snap = n_done;
        launch(32'hDEAD_BEEF, 2'd1, 1'b1, 1'b0, 8'd0, 1'b0, 32'd0);
        repeat (21) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", 32'(cs_n), 32'hF);
        chk("mid_rst_sck", 32'(sck), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_dout", dout, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_rst_no_done", 32'(n_done - snap), 32'd0);
        chk("mid_rst_idle_busy", 32'(busy), 32'd0);

        // back-to-back on the done cycle
        snap = n_done;
        launch(32'h5555_AAAA, 2'd1, 1'b0, 1'b0, 8'd1, 1'b1, 32'h5555_AAAA);
        wait_idle(4'b1101, w, bad);
        chk("b2b_first_done", 32'(done), 32'd1);
        chk("b2b_gap_cs", 32'(cs_n), 32'hF);
        launch(32'h3333_CCCC, 2'd1, 1'b0, 1'b0, 8'd1, 1'b1, 32'h3333_CCCC);
        chk("b2b_second_busy", 32'(busy), 32'd1);
        chk("b2b_second_cs", 32'(cs_n), 32'b1101);
        wait_idle(4'b1101, w, bad);
        chk("b2b_second_width", 32'(w), 32'd132);
        chk("b2b_cs_hold", 32'(bad), 32'd0);
        repeat (3) @(negedge clk);
        chk("b2b_done_count", 32'(n_done - snap), 32'd2);

`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b1;
        launch(32'h0000_0001, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, 32'h0000_0001);
        lsb_first = 1'b0;
        chk("lsb_first_bit", 32'(mosi), 32'd1);
        wait_idle(4'b1110, w, bad);
        chk("lsb_busy_width", 32'(w), 32'd66);
        repeat (3) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning bits per transfer (legal 8..32).
REQ-002 SHALL have parameter CS_NUM, default 4, meaning number of chip-select outputs (legal 1..8).
REQ-003 SHALL have parameter DIV_W, default 8, meaning clk_div width.
REQ-004 SHALL have port clk  input  1  system clock, single clock domain, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  transfer request, sampled only in IDLE.
REQ-007 SHALL have port busy  output  1  high while a transfer is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse at transfer end.
REQ-009 SHALL have port din  input  DATA_W  word to shift out on mosi.
REQ-010 SHALL have port dout  output  DATA_W  last received miso word, held until next done.
REQ-011 SHALL have port cs_sel  input  $clog2(CS_NUM) (min 1)  target slave index.
REQ-012 SHALL have ports cpol, cpha  input  1 each  SPI mode.
REQ-013 SHALL have port clk_div  input  DIV_W  SCK half-period = clk_div+1 clk cycles.
REQ-014 SHALL have ports sck  output  1, mosi  output  1, miso  input  1, cs_n  output  CS_NUM (active low).

Function
REQ-015 SHALL implement FSM IDLE -> LEAD -> XFER -> TRAIL -> IDLE.
REQ-016 SHALL, on start=1 in IDLE, latch din, cs_sel, cpol, cpha, clk_div (and lsb_first if compiled) and enter LEAD next cycle; later input changes ignored until IDLE.
REQ-017 SHALL ignore start while busy=1; no queuing.
REQ-018 SHALL assert busy and cs_n[cs_sel]=0 from the cycle after start acceptance; all other cs_n bits stay 1; cs_sel>=CS_NUM runs the transfer with no cs_n asserted.
REQ-019 SHALL hold LEAD one half-period, XFER exactly 2*DATA_W half-periods (DATA_W full SCK cycles), TRAIL one half-period; busy width = (2*DATA_W+2)*(clk_div+1) cycles.
REQ-020 SHALL drive sck = latched cpol in IDLE, LEAD, TRAIL; sck toggles at each XFER half-period boundary.
REQ-021 SHALL, for cpha=0, present first bit on mosi on entry to LEAD, sample miso on leading SCK edges, shift mosi on trailing edges.
REQ-022 SHALL, for cpha=1, shift mosi on leading edges (first bit at first leading edge), sample miso on trailing edges.
REQ-023 SHALL transmit/receive MSB first by default; received first bit ends in dout[DATA_W-1].
REQ-024 SHALL, at TRAIL end, in one cycle: deassert all cs_n, drop busy, update dout, pulse done.
REQ-025 SHALL accept a new start in the cycle done is high (back-to-back, cs_n high at least one cycle).
REQ-026 SHALL drive mosi=0 in IDLE.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-transfer, immediately force: FSM IDLE, cs_n all 1, sck 0, mosi 0, busy 0, done 0, dout 0, latched cpol 0; aborted transfer produces no done.

Configuration
REQ-028 SHALL compile port lsb_first (input 1) only when SPI_LSB_FIRST_EN is defined; lsb_first=1 latched at start makes both directions LSB first (first received bit in dout[0]).
REQ-029 SHALL, without SPI_LSB_FIRST_EN, omit lsb_first and always operate MSB first.

Structure
REQ-030 SHALL place FSM state enum and SPI mode typedef (cpol,cpha) in shared package spi_pkg.
REQ-031 SHALL use one sub-module spi_clk_gen producing a one-cycle half-period tick from latched clk_div, cleared in IDLE.

Verification
REQ-032 SHALL cover mode 0, DATA_W=32, clk_div=0, din=0xA5C3_0F81, miso looped to mosi -> dout=0xA5C3_0F81, busy width 66 cycles, one done pulse.
REQ-033 SHALL cover all four cpol/cpha modes, clk_div=3, miso model per mode returning 0x1234_5678 -> correct dout, sck idles at cpol, edge placement per REQ-021/022.
REQ-034 SHALL cover cs_sel=2, CS_NUM=4 -> only cs_n[2] low for the transfer; cs_sel=3 then start asserted during busy -> second start ignored, one done only.
REQ-035 SHALL cover rst_n pulsed low mid-XFER (bit 10) -> same-cycle cs_n=4'b1111, sck=0, busy=0, no done, dout=0.
REQ-036 SHALL cover back-to-back start on done cycle -> second transfer begins next cycle, cs_n high exactly one cycle between.
REQ-037 SHALL cover, with SPI_LSB_FIRST_EN, lsb_first=1, din=0x0000_0001, loopback -> first mosi bit 1, dout=0x0000_0001.
